// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, functs, ALU codes,
// datapath mux selects, FSM states and the bundled control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_NOR = 6'b100111;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_BRANCH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_IMM   = 2'b11
    } alu_op_t;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IEXEC  = 4'd9,
        S_IWB    = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    // PCWrite and Branch stay internal; they only feed the PCEn gate.
    typedef struct packed {
        logic       mem_write;
        logic       ir_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       ext_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       branch;
        logic       illegal;
        logic       done;
    } ctrl_t;

    function automatic logic is_imm_op(input logic [5:0] op);
        return (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI) || (op == OP_SLTI);
    endfunction

    // Logical immediates are zero-extended; arithmetic ones are sign-extended.
    function automatic logic zero_ext(input logic [5:0] op);
        return (op == OP_ANDI) || (op == OP_ORI);
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps ALUOp plus funct (R-type) or opcode (immediate ops)
// to the 4-bit ALUControl, flagging encodings the ALU does not support.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_t    alu_op_i,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output logic [3:0] alu_control_o,
    output logic       valid_o
);

    always_comb begin
        // NOTE: defaults first so every path through the case assigns both outputs (no latch).
        alu_control_o = ALU_ADD;
        valid_o       = 1'b1;
        case (alu_op_i)
            ALUOP_ADD: alu_control_o = ALU_ADD;
            ALUOP_SUB: alu_control_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FUNCT_ADD: alu_control_o = ALU_ADD;
                    FUNCT_SUB: alu_control_o = ALU_SUB;
                    FUNCT_AND: alu_control_o = ALU_AND;
                    FUNCT_OR:  alu_control_o = ALU_OR;
                    FUNCT_NOR: alu_control_o = ALU_NOR;
                    FUNCT_SLT: alu_control_o = ALU_SLT;
                    default:   valid_o       = 1'b0;
                endcase
            end
            ALUOP_IMM: begin
                case (op_i)
                    OP_ADDI: alu_control_o = ALU_ADD;
                    OP_ANDI: alu_control_o = ALU_AND;
                    OP_ORI:  alu_control_o = ALU_OR;
                    OP_SLTI: alu_control_o = ALU_SLT;
                    default: valid_o       = 1'b0;
                endcase
            end
            default: valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: Moore FSM sequencing fetch/decode/execute/memory/
// writeback, with the ALU decoder and the PCEn branch gate.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter state_t RESET_STATE = S_FETCH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       mem_ready,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       IorD,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       ExtOp,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       PCEn,
    output logic [3:0] ALUControl,
    output logic       illegal_instr,
    output logic       instr_done
);

    state_t     state_q, state_d;
    ctrl_t      ctrl_raw, ctrl;
    alu_op_t    alu_op;
    logic [3:0] dec_control;
    logic       dec_valid;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_d;
        end
    end

    // Keyed on state only, so the decode legality check never loops back into itself.
    // In DECODE the funct path is selected purely to validate R-type functs.
    always_comb begin
        alu_op = ALUOP_ADD;
        case (state_q)
            S_DECODE, S_EXEC: alu_op = ALUOP_FUNCT;
            S_IEXEC:          alu_op = ALUOP_IMM;
            S_BRANCH:         alu_op = ALUOP_SUB;
            default:          alu_op = ALUOP_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op_i      (alu_op),
        .op_i          (op),
        .funct_i       (funct),
        .alu_control_o (dec_control),
        .valid_o       (dec_valid)
    );

    always_comb begin
        state_d  = state_q;
        ctrl_raw = '0;
        case (state_q)
            S_FETCH: begin
                ctrl_raw.alu_src_b = SRCB_FOUR;
                ctrl_raw.pc_src    = PCSRC_ALU;
                if (mem_ready) begin
                    ctrl_raw.ir_write = 1'b1;
                    ctrl_raw.pc_write = 1'b1;
                    state_d           = S_DECODE;
                end
            end
            S_DECODE: begin
                ctrl_raw.alu_src_b = SRCB_BRANCH;
                if (op == OP_LW || op == OP_SW) begin
                    state_d = S_MEMADR;
                end else if (op == OP_RTYPE && dec_valid) begin
                    state_d = S_EXEC;
                end else if (op == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (is_imm_op(op)) begin
                    state_d = S_IEXEC;
                end else if (op == OP_J) begin
                    state_d = S_JUMP;
                end else begin
                    ctrl_raw.illegal = 1'b1;
                    state_d          = S_FETCH;
                end
            end
            S_MEMADR: begin
                ctrl_raw.alu_src_a = 1'b1;
                ctrl_raw.alu_src_b = SRCB_IMM;
                if (op == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (op == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD: begin
                ctrl_raw.iord = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEMWB;
                end
            end
            S_MEMWB: begin
                ctrl_raw.mem_to_reg = 1'b1;
                ctrl_raw.reg_write  = 1'b1;
                ctrl_raw.done       = 1'b1;
                state_d             = S_FETCH;
            end
            S_MEMWR: begin
                ctrl_raw.iord      = 1'b1;
                ctrl_raw.mem_write = 1'b1;
                if (mem_ready) begin
                    ctrl_raw.done = 1'b1;
                    state_d       = S_FETCH;
                end
            end
            S_EXEC: begin
                ctrl_raw.alu_src_a = 1'b1;
                ctrl_raw.alu_src_b = SRCB_REG;
                state_d            = S_ALUWB;
            end
            S_ALUWB: begin
                ctrl_raw.reg_dst   = 1'b1;
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.done      = 1'b1;
                state_d            = S_FETCH;
            end
            S_BRANCH: begin
                ctrl_raw.alu_src_a = 1'b1;
                ctrl_raw.alu_src_b = SRCB_REG;
                ctrl_raw.branch    = 1'b1;
                ctrl_raw.pc_src    = PCSRC_ALUOUT;
                ctrl_raw.done      = 1'b1;
                state_d            = S_FETCH;
            end
            S_IEXEC: begin
                ctrl_raw.alu_src_a = 1'b1;
                ctrl_raw.alu_src_b = SRCB_IMM;
                ctrl_raw.ext_op    = zero_ext(op);
                state_d            = S_IWB;
            end
            S_IWB: begin
                ctrl_raw.reg_write = 1'b1;
                ctrl_raw.ext_op    = zero_ext(op);
                ctrl_raw.done      = 1'b1;
                state_d            = S_FETCH;
            end
            S_JUMP: begin
                ctrl_raw.pc_src   = PCSRC_JUMP;
                ctrl_raw.pc_write = 1'b1;
                ctrl_raw.done     = 1'b1;
                state_d           = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every control in the same cycle, including a stalled store.
    assign ctrl = reset ? '0 : ctrl_raw;

    assign MemWrite      = ctrl.mem_write;
    assign IRWrite       = ctrl.ir_write;
    assign IorD          = ctrl.iord;
    assign RegDst        = ctrl.reg_dst;
    assign MemtoReg      = ctrl.mem_to_reg;
    assign RegWrite      = ctrl.reg_write;
    assign ALUSrcA       = ctrl.alu_src_a;
    assign ExtOp         = ctrl.ext_op;
    assign ALUSrcB       = ctrl.alu_src_b;
    assign PCSrc         = ctrl.pc_src;
    assign PCEn          = ctrl.pc_write | (ctrl.branch & Zero);
    assign illegal_instr = ctrl.illegal;
    assign instr_done    = ctrl.done;
    assign ALUControl    = (reset || state_q == S_DECODE) ? ALU_ADD : dec_control;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class cycle by cycle
// and compares the full control word against hand-derived values.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       MemWrite, IRWrite, IorD, RegDst, MemtoReg, RegWrite, ALUSrcA, ExtOp;
    logic [1:0] ALUSrcB, PCSrc;
    logic       PCEn;
    logic [3:0] ALUControl;
    logic       illegal_instr, instr_done;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .op            (op),
        .funct         (funct),
        .Zero          (zero),
        .mem_ready     (mem_ready),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .IorD          (IorD),
        .RegDst        (RegDst),
        .MemtoReg      (MemtoReg),
        .RegWrite      (RegWrite),
        .ALUSrcA       (ALUSrcA),
        .ExtOp         (ExtOp),
        .ALUSrcB       (ALUSrcB),
        .PCSrc         (PCSrc),
        .PCEn          (PCEn),
        .ALUControl    (ALUControl),
        .illegal_instr (illegal_instr),
        .instr_done    (instr_done)
    );

    typedef struct packed {
        logic       mem_write;
        logic       ir_write;
        logic       iord;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic       ext_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic [3:0] alu_ctl;
        logic       illegal;
        logic       done;
    } want_t;

    want_t obs;
    assign obs = {MemWrite, IRWrite, IorD, RegDst, MemtoReg, RegWrite, ALUSrcA, ExtOp,
                  ALUSrcB, PCSrc, PCEn, ALUControl, illegal_instr, instr_done};

    function automatic want_t base();
        want_t w;
        w         = '0;
        w.alu_ctl = 4'b0010;
        return w;
    endfunction

    function automatic want_t e_rst();
        return base();
    endfunction

    function automatic want_t e_fetch(input logic rdy);
        want_t w = base();
        w.alu_src_b = 2'b01;
        w.ir_write  = rdy;
        w.pc_en     = rdy;
        return w;
    endfunction

    function automatic want_t e_dec(input logic ill);
        want_t w = base();
        w.alu_src_b = 2'b11;
        w.illegal   = ill;
        return w;
    endfunction

    function automatic want_t e_madr();
        want_t w = base();
        w.alu_src_a = 1'b1;
        w.alu_src_b = 2'b10;
        return w;
    endfunction

    function automatic want_t e_mrd();
        want_t w = base();
        w.iord = 1'b1;
        return w;
    endfunction

    function automatic want_t e_mwb();
        want_t w = base();
        w.mem_to_reg = 1'b1;
        w.reg_write  = 1'b1;
        w.done       = 1'b1;
        return w;
    endfunction

    function automatic want_t e_mwr(input logic rdy);
        want_t w = base();
        w.iord      = 1'b1;
        w.mem_write = 1'b1;
        w.done      = rdy;
        return w;
    endfunction

    function automatic want_t e_exec(input logic [3:0] ctl);
        want_t w = base();
        w.alu_src_a = 1'b1;
        w.alu_ctl   = ctl;
        return w;
    endfunction

    function automatic want_t e_alwb();
        want_t w = base();
        w.reg_dst   = 1'b1;
        w.reg_write = 1'b1;
        w.done      = 1'b1;
        return w;
    endfunction

    function automatic want_t e_br(input logic z);
        want_t w = base();
        w.alu_src_a = 1'b1;
        w.alu_ctl   = 4'b0110;
        w.pc_src    = 2'b01;
        w.pc_en     = z;
        w.done      = 1'b1;
        return w;
    endfunction

    function automatic want_t e_iex(input logic [3:0] ctl, input logic ext);
        want_t w = base();
        w.alu_src_a = 1'b1;
        w.alu_src_b = 2'b10;
        w.alu_ctl   = ctl;
        w.ext_op    = ext;
        return w;
    endfunction

    function automatic want_t e_iwb(input logic ext);
        want_t w = base();
        w.reg_write = 1'b1;
        w.ext_op    = ext;
        w.done      = 1'b1;
        return w;
    endfunction

    function automatic want_t e_jmp();
        want_t w = base();
        w.pc_src = 2'b10;
        w.pc_en  = 1'b1;
        w.done   = 1'b1;
        return w;
    endfunction

    task automatic check(input string tag, input want_t want);
        n_tests++;
        assert (obs === want) else begin
            n_fail++;
            $error("FAIL %s: observed=%05h expected=%05h", tag, obs, want);
        end
    endtask

    // Inputs are applied 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic cyc(input string tag, input want_t want);
        #1;
        check(tag, want);
        @(posedge clk);
        #1;
    endtask

    task automatic run_r(input logic [5:0] f, input logic [3:0] ctl, input string tag);
        op = 6'b000000; funct = f; mem_ready = 1'b1;
        cyc({tag, "_fetch"}, e_fetch(1'b1));
        cyc({tag, "_decode"}, e_dec(1'b0));
        cyc({tag, "_exec"}, e_exec(ctl));
        cyc({tag, "_wb"}, e_alwb());
    endtask

    task automatic run_imm(input logic [5:0] o, input logic [3:0] ctl, input logic ext,
                           input string tag);
        op = o; funct = 6'b000000; mem_ready = 1'b1;
        cyc({tag, "_fetch"}, e_fetch(1'b1));
        cyc({tag, "_decode"}, e_dec(1'b0));
        cyc({tag, "_iexec"}, e_iex(ctl, ext));
        cyc({tag, "_iwb"}, e_iwb(ext));
    endtask

    initial begin
        reset = 1'b1; op = 6'b100011; funct = 6'b000000; zero = 1'b0; mem_ready = 1'b1;

        // Reset held for two edges: everything low, ALUControl at ADD.
        @(posedge clk); #1;
        cyc("reset_c1", e_rst());
        cyc("reset_c2", e_rst());
        reset = 1'b0;

        run_r(6'b100010, 4'b0110, "r_sub");
        run_r(6'b101010, 4'b0111, "r_slt");
        run_r(6'b100111, 4'b1100, "r_nor");
        run_r(6'b100000, 4'b0010, "r_add");
        run_r(6'b100101, 4'b0001, "r_or");

        // lw: 3 FETCH stall cycles, 2 MEMRD stall cycles; writeback lands on cycle 10.
        op = 6'b100011; funct = 6'b000000; mem_ready = 1'b0;
        cyc("lw_fetch_stall1", e_fetch(1'b0));
        cyc("lw_fetch_stall2", e_fetch(1'b0));
        cyc("lw_fetch_stall3", e_fetch(1'b0));
        mem_ready = 1'b1;
        cyc("lw_fetch", e_fetch(1'b1));
        cyc("lw_decode", e_dec(1'b0));
        cyc("lw_memadr", e_madr());
        mem_ready = 1'b0;
        cyc("lw_memrd_stall1", e_mrd());
        cyc("lw_memrd_stall2", e_mrd());
        mem_ready = 1'b1;
        cyc("lw_memrd", e_mrd());
        cyc("lw_memwb_c10", e_mwb());

        // beq taken, then not taken; Zero high in DECODE must not open PCEn.
        op = 6'b000100; zero = 1'b1; mem_ready = 1'b1;
        cyc("beq_t_fetch", e_fetch(1'b1));
        cyc("beq_t_decode", e_dec(1'b0));
        cyc("beq_t_branch", e_br(1'b1));
        zero = 1'b0;
        cyc("beq_n_fetch", e_fetch(1'b1));
        cyc("beq_n_decode", e_dec(1'b0));
        cyc("beq_n_branch", e_br(1'b0));

        run_imm(6'b001100, 4'b0000, 1'b1, "andi");
        run_imm(6'b001101, 4'b0001, 1'b1, "ori");
        run_imm(6'b001010, 4'b0111, 1'b0, "slti");
        run_imm(6'b001000, 4'b0010, 1'b0, "addi");

        op = 6'b000010; mem_ready = 1'b1;
        cyc("j_fetch", e_fetch(1'b1));
        cyc("j_decode", e_dec(1'b0));
        cyc("j_jump", e_jmp());

        // Illegal opcode, then R-type with an unsupported funct.
        op = 6'b111111;
        cyc("ill_op_fetch", e_fetch(1'b1));
        cyc("ill_op_decode", e_dec(1'b1));
        op = 6'b000000; funct = 6'b000001;
        cyc("ill_fn_fetch", e_fetch(1'b1));
        cyc("ill_fn_decode", e_dec(1'b1));
        mem_ready = 1'b0;
        cyc("ill_back_fetch", e_fetch(1'b0));

        // sw with no stall.
        op = 6'b101011; funct = 6'b000000; mem_ready = 1'b1;
        cyc("sw_fetch", e_fetch(1'b1));
        cyc("sw_decode", e_dec(1'b0));
        cyc("sw_memadr", e_madr());
        cyc("sw_memwr", e_mwr(1'b1));

        // sw stalled in MEMWR, then reset during the stall.
        cyc("sw2_fetch", e_fetch(1'b1));
        cyc("sw2_decode", e_dec(1'b0));
        cyc("sw2_memadr", e_madr());
        mem_ready = 1'b0;
        cyc("sw2_memwr_stall", e_mwr(1'b0));
        reset = 1'b1;
        cyc("sw2_reset_cycle", e_rst());
        reset = 1'b0;
        cyc("sw2_after_reset_fetch", e_fetch(1'b0));
        mem_ready = 1'b1;
        cyc("sw2_refetch", e_fetch(1'b1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
